// File: rtl/apb_completer_mux.sv
// APB completer-side mux: decodes one upstream APB requester onto NO_OF_SLAVES
// downstream completers, answers unmapped addresses itself and times out stalled slaves.
module apb_completer_mux #(
    parameter int                    NO_OF_SLAVES   = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    REGION_BITS    = 12,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                               pclk,
    input  logic                               preset,
    // upstream
    input  logic                               psel,
    input  logic                               penable,
    input  logic                               pwrite,
    input  logic [ADDR_WIDTH-1:0]              paddr,
    input  logic [DATA_WIDTH-1:0]              pwdata,
    input  logic [DATA_WIDTH/8-1:0]            pstrb,
    input  logic [2:0]                         pprot,
    output logic [DATA_WIDTH-1:0]              prdata,
    output logic                               pready,
    output logic                               pslverr,
    // downstream
    output logic [NO_OF_SLAVES-1:0]            psel_o,
    output logic                               penable_o,
    output logic                               pwrite_o,
    output logic [ADDR_WIDTH-1:0]              paddr_o,
    output logic [DATA_WIDTH-1:0]              pwdata_o,
    output logic [DATA_WIDTH/8-1:0]            pstrb_o,
    output logic [2:0]                         pprot_o,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata_i,
    input  logic [NO_OF_SLAVES-1:0]            pready_i,
    input  logic [NO_OF_SLAVES-1:0]            pslverr_i,
    // status
    output logic [7:0]                         err_count
);

    // state  | meaning
    // IDLE   | no transfer open, all selects low, no response upstream
    // SETUP  | master setup phase (psel=1, penable=0); decode is captured
    // ACCESS | access phase open to the captured slave, or answered locally if unmapped

    localparam int IW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]         CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [ADDR_WIDTH-1:0] SLV_CNT  = ADDR_WIDTH'(NO_OF_SLAVES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state;
    state_t                  state_d;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   region;
    logic                    dec_hit;
    logic [IW-1:0]           dec_idx;

    logic                    hit_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;

    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    timeout_fire;
    logic                    complete;

    assign offset  = paddr - BASE_ADDR;
    assign region  = offset >> REGION_BITS;
    assign dec_hit = (paddr >= BASE_ADDR) && (region < SLV_CNT);
    assign dec_idx = region[IW-1:0];

    assign penable_o = penable;
    assign pwrite_o  = pwrite;
    assign paddr_o   = paddr;
    assign pwdata_o  = pwdata;
    assign pstrb_o   = pstrb;
    assign pprot_o   = pprot;

    // SETUP is recognised straight from the bus so the slave select leaves in the
    // same cycle as the master's setup phase; the register only tracks an open access.
    always_comb begin
        state = state_q;
        if (preset) begin
            state = IDLE;
        end else if (state_q != ACCESS) begin
            state = (psel && !penable) ? SETUP : IDLE;
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NO_OF_SLAVES; k++) begin
            if (hit_q && (idx_q == IW'(k))) begin
                sel_ready = pready_i[k];
                sel_err   = pslverr_i[k];
                sel_data  = prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // a slave answering on the timeout cycle takes precedence over the timeout
    assign timeout_fire = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST) && !sel_ready;

    always_comb begin
        psel_o   = '0;
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        complete = 1'b0;
        case (state)
            SETUP: begin
                for (int k = 0; k < NO_OF_SLAVES; k++) begin
                    psel_o[k] = psel && dec_hit && (dec_idx == IW'(k));
                end
            end
            ACCESS: begin
                if (hit_q) begin
                    for (int k = 0; k < NO_OF_SLAVES; k++) begin
                        psel_o[k] = psel && (idx_q == IW'(k));
                    end
                    pready  = sel_ready || timeout_fire;
                    pslverr = sel_ready ? sel_err : timeout_fire;
                    prdata  = timeout_fire ? '0 : sel_data;
                end else begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end
                complete = psel && pready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = IDLE;
        case (state)
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (!psel || complete) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((state == ACCESS) && psel && !complete && !sel_ready) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state == SETUP) begin
                hit_q <= dec_hit;
                idx_q <= dec_idx;
            end
            if (complete && pslverr && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_completer_mux.sv
// Directed and randomized APB transfers against apb_completer_mux; expected
// responses come from a transfer-level model of decode, wait states and timeout.
module tb_apb_completer_mux;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic [2:0]        pprot;
    logic [DW-1:0]     prdata;
    logic              pready, pslverr;
    logic [N-1:0]      psel_o;
    logic              penable_o, pwrite_o;
    logic [AW-1:0]     paddr_o;
    logic [DW-1:0]     pwdata_o;
    logic [DW/8-1:0]   pstrb_o;
    logic [2:0]        pprot_o;
    logic [N*DW-1:0]   prdata_i;
    logic [N-1:0]      pready_i, pslverr_i;
    logic [7:0]        err_count;

    int checks   = 0;
    int failures = 0;
    int err_model = 0;

    always #5 pclk = ~pclk;

    apb_completer_mux #(
        .NO_OF_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BASE_ADDR(32'h0), .REGION_BITS(12), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .err_count(err_count)
    );

    initial begin
        #500us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // k<0 randomizes every slave; otherwise slave k gets the given response
    task automatic set_slaves(input int k, input bit rdy, input bit err, input logic [DW-1:0] data);
        for (int j = 0; j < N; j++) begin
            if (j == k) begin
                pready_i[j]             = rdy;
                pslverr_i[j]            = err;
                prdata_i[j*DW +: DW]    = data;
            end else begin
                pready_i[j]             = 1'($urandom);
                pslverr_i[j]            = 1'($urandom);
                prdata_i[j*DW +: DW]    = $urandom;
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge pclk);
        chk({tag, "_psel_o"},  64'(psel_o),    64'd0);
        chk({tag, "_pready"},  64'(pready),    64'd0);
        chk({tag, "_pslverr"}, 64'(pslverr),   64'd0);
        chk({tag, "_prdata"},  64'(prdata),    64'd0);
        chk({tag, "_errcnt"},  64'(err_count), 64'(err_model));
    endtask

    // Called at posedge+1 with the bus idle or just after a completion.
    task automatic xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                        input int waitc, input bit serr, input logic [DW-1:0] rdata, input bit b2b);
        bit            hit;
        int            k;
        int            done_n;
        bit            exp_err;
        logic [DW-1:0] exp_data;
        logic [N-1:0]  exp_sel;
        bit            rdy;
        bit            last;
        hit     = ((addr >> 12) < N);
        k       = hit ? int'(addr >> 12) : -1;
        exp_sel = hit ? N'(1 << k) : '0;
        if (!hit) begin
            done_n = 1; exp_err = 1'b1; exp_data = '0;
        end else if (waitc < TO) begin
            done_n = waitc + 1; exp_err = serr; exp_data = rdata;
        end else begin
            done_n = TO; exp_err = 1'b1; exp_data = '0;
        end

        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        pstrb = 4'($urandom); pprot = 3'($urandom);
        set_slaves(-1, 1'b0, 1'b0, '0);
        @(negedge pclk);
        chk("setup_psel_o",  64'(psel_o),    64'(exp_sel));
        chk("setup_pready",  64'(pready),    64'd0);
        chk("setup_pslverr", 64'(pslverr),   64'd0);
        chk("setup_prdata",  64'(prdata),    64'd0);
        chk("setup_errcnt",  64'(err_count), 64'(err_model));
        chk("pass_paddr",    64'(paddr_o),   64'(addr));
        chk("pass_ctl",      64'({pwrite_o, penable_o, pwdata_o, pstrb_o, pprot_o}),
                             64'({wr, 1'b0, wdata, pstrb, pprot}));
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int n = 1; n <= done_n; n++) begin
            last = (n == done_n);
            rdy  = hit && (n > waitc);
            set_slaves(k, rdy, rdy ? serr : 1'b0, rdy ? rdata : DW'($urandom));
            @(negedge pclk);
            chk("acc_psel_o",  64'(psel_o),  64'(exp_sel));
            chk("acc_pready",  64'(pready),  64'(last));
            chk("acc_pslverr", 64'(pslverr), 64'(last ? exp_err : 1'b0));
            if (last) chk("acc_prdata", 64'(prdata), 64'(exp_data));
            @(posedge pclk); #1;
        end
        if (exp_err && err_model < 255) err_model++;
        penable = 1'b0;
        if (!b2b) begin
            psel = 1'b0;
            set_slaves(-1, 1'b0, 1'b0, '0);
            idle_check("post");
            @(posedge pclk); #1;
        end
    endtask

    initial begin
        preset = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        set_slaves(-1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            psel = 1'($urandom); penable = 1'($urandom); paddr = 32'($urandom_range(0, 32'h5FFF));
            set_slaves(-1, 1'b0, 1'b0, '0);
            idle_check("rst");
        end
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        idle_check("post_rst");
        @(posedge pclk); #1;

        // directed
        xfer(32'h0000_1004, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, 32'h0, 1'b0);
        xfer(32'h0000_3010, 1'b0, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        xfer(32'h0000_5000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_2222, 1'b0);
        xfer(32'h0000_2000, 1'b0, 32'h0, 40, 1'b0, 32'h3333_4444, 1'b0);
        xfer(32'h0000_2abc, 1'b0, 32'h0, 15, 1'b0, 32'h1234_5678, 1'b0);
        xfer(32'h0000_1800, 1'b1, 32'h0, 2, 1'b1, 32'h0, 1'b0);
        xfer(32'h0000_0000, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1'b1);
        xfer(32'h0000_3ffc, 1'b0, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1'b1);
        xfer(32'h0000_4000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
        xfer(32'h0000_0ffc, 1'b0, 32'h0, 0, 1'b1, 32'h7777_8888, 1'b0);

        // randomized
        for (int i = 0; i < 40; i++) begin
            int            r;
            logic [AW-1:0] a;
            int            w;
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 5);
            if (r <= 6) a = {18'h0, 2'($urandom_range(0, 3)), 12'($urandom)};
            else if (r <= 8) a = 32'h4000 + 32'($urandom_range(0, 32'h7FFF_FFFF));
            else begin
                a = {18'h0, 2'($urandom_range(0, 3)), 12'($urandom)};
                w = $urandom_range(14, 20);
            end
            xfer(a, 1'($urandom), $urandom, w, ($urandom_range(0, 3) == 0), $urandom,
                 (i != 39) && 1'($urandom));
        end

        // reset on the second access cycle of a stalled transfer
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_2040; pwrite = 1'b0;
        set_slaves(-1, 1'b0, 1'b0, '0);
        @(negedge pclk);
        chk("rmid_setup_psel_o", 64'(psel_o), 64'h4);
        @(posedge pclk); #1;
        penable = 1'b1;
        set_slaves(2, 1'b0, 1'b0, $urandom);
        @(negedge pclk);
        chk("rmid_acc1_pready", 64'(pready), 64'd0);
        @(posedge pclk); #1;
        preset = 1'b1;
        set_slaves(2, 1'b0, 1'b0, $urandom);
        @(negedge pclk);
        chk("rmid_rst_pready", 64'(pready), 64'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        err_model = 0;
        idle_check("rmid_after");
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        idle_check("rmid_idle");
        @(posedge pclk); #1;

        // saturation
        for (int i = 0; i < 256; i++) begin
            xfer(32'h4000 + 32'($urandom_range(0, 32'h0FFF_FFFF)), 1'($urandom), $urandom,
                 0, 1'b0, 32'h0, (i != 255));
        end
        @(negedge pclk);
        chk("err_sat", 64'(err_count), 64'd255);
        @(posedge pclk); #1;
        xfer(32'h0000_6000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge pclk);
        chk("err_sat_hold", 64'(err_count), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_completer_mux.md
APB_COMPLETER_MUX -- requirements
Module: apb_completer_mux

Interface
REQ-001 SHALL have parameter NO_OF_SLAVES, default 4, number of downstream completers (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, APB data width (8/16/32).
REQ-004 SHALL have parameter BASE_ADDR, default 0, start of the decoded window.
REQ-005 SHALL have parameter REGION_BITS, default 12, log2 of per-slave region size.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, access-phase wait limit; 0 disables the timeout.
REQ-007 SHALL have ports pclk in 1, the single clock; preset in 1, synchronous active-high reset.
REQ-008 SHALL have upstream inputs psel 1, penable 1, pwrite 1, paddr ADDR_WIDTH, pwdata DATA_WIDTH, pstrb DATA_WIDTH/8, pprot 3.
REQ-009 SHALL have upstream outputs prdata DATA_WIDTH, pready 1, pslverr 1.
REQ-010 SHALL have downstream outputs psel_o NO_OF_SLAVES, penable_o 1, pwrite_o 1, paddr_o ADDR_WIDTH, pwdata_o DATA_WIDTH, pstrb_o DATA_WIDTH/8, pprot_o 3.
REQ-011 SHALL have downstream inputs prdata_i NO_OF_SLAVES*DATA_WIDTH (slave k at bits k*DATA_WIDTH upward), pready_i NO_OF_SLAVES, pslverr_i NO_OF_SLAVES.
REQ-012 SHALL have output err_count 8, saturating count of error completions.

Function
REQ-013 SHALL decode idx = (paddr - BASE_ADDR) >> REGION_BITS; hit when paddr >= BASE_ADDR and idx < NO_OF_SLAVES, else unmapped.
REQ-014 SHALL run FSM IDLE / SETUP / ACCESS: IDLE->SETUP on psel=1; SETUP->ACCESS unconditionally; ACCESS->SETUP on completion with psel=1 and penable=0 in the next cycle, else ACCESS->IDLE on completion.
REQ-015 SHALL register idx and hit at the SETUP cycle; ACCESS uses the registered values only.
REQ-016 SHALL drive psel_o[idx]=psel combinationally during SETUP on hit, hold it through ACCESS until completion, and keep all other psel_o bits 0.
REQ-017 SHALL pass penable, pwrite, paddr, pwdata, pstrb, pprot to all slaves combinationally (zero latency).
REQ-018 SHALL, in ACCESS with hit, forward prdata_i/pready_i/pslverr_i of the registered slave combinationally to prdata/pready/pslverr.
REQ-019 SHALL, in ACCESS with unmapped, assert pready=1 and pslverr=1 with prdata=0 on the first ACCESS cycle and assert no psel_o bit.
REQ-020 SHALL count ACCESS cycles with selected pready_i=0 in a counter sized for TIMEOUT_CYCLES, clearing it on every completion and in SETUP.
REQ-021 SHALL, when TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 with pready_i still 0, force pready=1, pslverr=1, prdata=0 upstream and end the transfer (psel_o drops next cycle).
REQ-022 SHALL treat a simultaneous slave pready_i=1 and timeout cycle as a normal slave completion (slave response wins).
REQ-023 SHALL drive pready=0, pslverr=0, prdata=0 in IDLE and SETUP.
REQ-024 SHALL increment err_count by 1 on each completion with pslverr=1 (slave error, unmapped, or timeout), saturating at 255.
REQ-025 SHALL, if psel falls during ACCESS before completion (protocol violation), return to IDLE, drop psel_o, and not count an error.

Reset
REQ-026 SHALL, while preset=1 at a pclk edge, enter IDLE, clear the timeout counter, registered idx/hit and err_count.
REQ-027 SHALL hold psel_o=0, pready=0, pslverr=0, prdata=0 while in IDLE after reset, regardless of upstream inputs during reset.
REQ-028 SHALL abandon an in-flight transfer on reset mid-ACCESS with no upstream completion and no error count.

Verification
REQ-029 Write paddr=0x1004, pwdata=0xA5A5A5A5, slave1 pready_i=1 immediately -> psel_o=4'b0010 in SETUP and ACCESS, pready=1 in first ACCESS cycle, pslverr=0, err_count=0.
REQ-030 Read paddr=0x3010, slave3 prdata_i=0xDEADBEEF after 3 wait cycles -> pready=0 for 3 ACCESS cycles, then prdata=0xDEADBEEF with pready=1.
REQ-031 Read paddr=0x5000 (unmapped, N=4) -> psel_o=0 throughout, first ACCESS cycle pready=1, pslverr=1, prdata=0, err_count=1.
REQ-032 Slave2 holds pready_i=0, TIMEOUT_CYCLES=16 -> pready=1, pslverr=1 on the 16th ACCESS cycle, psel_o[2]=0 next cycle, err_count increments by 1.
REQ-033 Back-to-back transfers to slave0 then slave3 with psel held high -> ACCESS->SETUP with no IDLE cycle, psel_o moves 4'b0001 to 4'b1000, each completes once.
REQ-034 preset=1 on the 2nd ACCESS cycle of a waiting transfer -> next cycle IDLE, psel_o=0, pready=0, err_count=0; 256 unmapped accesses -> err_count=255.
